// File: rtl/num_one_counter_arbiter_if.sv
// Bundle of requester, counter and response signals for the one-counter arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface num_one_counter_arbiter_if #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int RES_WIDTH  = 4
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ*DATA_WIDTH-1:0] req_data;
  logic [N_REQ-1:0]            req_ready;
  logic                        cnt_data_valid;
  logic [DATA_WIDTH-1:0]       cnt_data_in;
  logic                        cnt_data_ready;
  logic [RES_WIDTH-1:0]        cnt_num_of_one;
  logic [RES_WIDTH-1:0]        cnt_max_index;
  logic [RES_WIDTH-1:0]        cnt_min_index;
  logic                        rsp_valid;
  logic [ID_W-1:0]             rsp_id;
  logic                        rsp_err;
  logic [RES_WIDTH-1:0]        rsp_num_of_one;
  logic [RES_WIDTH-1:0]        rsp_max_index;
  logic [RES_WIDTH-1:0]        rsp_min_index;
  logic                        busy;
  logic [7:0]                  err_count;

  modport slave (
    input  req_valid, req_data, cnt_data_ready,
           cnt_num_of_one, cnt_max_index, cnt_min_index,
    output req_ready, cnt_data_valid, cnt_data_in, rsp_valid, rsp_id, rsp_err,
           rsp_num_of_one, rsp_max_index, rsp_min_index, busy, err_count
  );

  modport master (
    output req_valid, req_data, cnt_data_ready,
           cnt_num_of_one, cnt_max_index, cnt_min_index,
    input  req_ready, cnt_data_valid, cnt_data_in, rsp_valid, rsp_id, rsp_err,
           rsp_num_of_one, rsp_max_index, rsp_min_index, busy, err_count
  );
endinterface

// File: rtl/num_one_counter_arbiter.sv
// Round-robin arbiter sharing one bit-one counter among N_REQ requesters,
// with a watchdog that turns a hung counter transaction into an error response.
module num_one_counter_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int RES_WIDTH  = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  num_one_counter_arbiter_if.slave  bus
);
  localparam int ID_W = $clog2(N_REQ);
  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [ID_W-1:0]       r_ptr;
  logic [ID_W-1:0]       r_cur_id;
  logic [ID_W-1:0]       r_rsp_id;
  logic [DATA_WIDTH-1:0] r_data;
  logic [WD_W-1:0]       r_wd;
  logic                  r_err;
  logic [RES_WIDTH-1:0]  r_num;
  logic [RES_WIDTH-1:0]  r_max;
  logic [RES_WIDTH-1:0]  r_min;
  logic [7:0]            r_err_cnt;

  logic                  w_any;
  logic [2*N_REQ-1:0]    w_dbl;
  logic [N_REQ-1:0]      w_rot;
  logic [ID_W-1:0]       w_off;
  logic [ID_W:0]         w_sum;
  logic [ID_W-1:0]       w_sel;
  logic [ID_W-1:0]       w_ptr_next;
  logic                  w_grant;
  logic [N_REQ-1:0]      w_ready;
  logic                  w_timeout;

  // Rotate requests so the pointer position becomes bit 0, then take the lowest set bit.
  assign w_any = |bus.req_valid;
  assign w_dbl = {bus.req_valid, bus.req_valid} >> r_ptr;
  assign w_rot = w_dbl[N_REQ-1:0];

  always_comb begin
    w_off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = ID_W'(i);
    end
  end

  assign w_sum      = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_sel      = (w_sum >= (ID_W+1)'(N_REQ)) ? ID_W'(w_sum - (ID_W+1)'(N_REQ))
                                                  : w_sum[ID_W-1:0];
  assign w_ptr_next = (w_sel == ID_W'(N_REQ - 1)) ? '0 : w_sel + ID_W'(1);
  // No grant may leak out while the block is held in reset.
  assign w_grant    = w_any && (r_state == S_IDLE) && rstn;
  assign w_timeout  = (r_wd == WD_W'(TIMEOUT - 2));

  always_comb begin
    w_ready = '0;
    if (w_grant) w_ready[w_sel] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_state_next = S_ISSUE;
      S_ISSUE: w_state_next = S_WAIT;
      S_WAIT:  if (bus.cnt_data_ready || w_timeout) w_state_next = S_RESP;
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ptr     <= '0;
      r_cur_id  <= '0;
      r_rsp_id  <= '0;
      r_data    <= '0;
      r_wd      <= '0;
      r_err     <= 1'b0;
      r_num     <= '0;
      r_max     <= '0;
      r_min     <= '0;
      r_err_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_data   <= bus.req_data[w_sel*DATA_WIDTH +: DATA_WIDTH];
            r_cur_id <= w_sel;
            r_ptr    <= w_ptr_next;
          end
        end
        S_ISSUE: r_wd <= '0;
        S_WAIT: begin
          // A completion arriving on the timeout cycle still counts as success.
          if (bus.cnt_data_ready) begin
            r_num    <= bus.cnt_num_of_one;
            r_max    <= bus.cnt_max_index;
            r_min    <= bus.cnt_min_index;
            r_err    <= 1'b0;
            r_rsp_id <= r_cur_id;
          end else if (w_timeout) begin
            r_num    <= '0;
            r_max    <= '0;
            r_min    <= '0;
            r_err    <= 1'b1;
            r_rsp_id <= r_cur_id;
            if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
          end else begin
            r_wd <= r_wd + WD_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready      = w_ready;
  assign bus.cnt_data_valid = (r_state == S_ISSUE);
  assign bus.cnt_data_in    = r_data;
  assign bus.rsp_valid      = (r_state == S_RESP);
  assign bus.rsp_id         = r_rsp_id;
  assign bus.rsp_err        = r_err;
  assign bus.rsp_num_of_one = r_num;
  assign bus.rsp_max_index  = r_max;
  assign bus.rsp_min_index  = r_min;
  assign bus.busy           = (r_state != S_IDLE);
  assign bus.err_count      = r_err_cnt;
endmodule

// File: tb/tb_num_one_counter_arbiter.sv
// Directed bench for num_one_counter_arbiter: a per-cycle vector table plus
// hand-written sequences for rotation, fairness, watchdog timeout and reset in WAIT.
module tb_num_one_counter_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int RW = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  num_one_counter_arbiter_if #(.N_REQ(N), .DATA_WIDTH(DW), .RES_WIDTH(RW)) bus ();

  num_one_counter_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .RES_WIDTH(RW), .TIMEOUT(TO)) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] words [N];

  typedef struct {
    logic [3:0] rv;
    logic       crdy;
    logic [3:0] cn, cx, cm;
    logic [3:0] e_rr;
    logic       e_cv;
    logic [7:0] e_cdin;
    logic       e_rsp;
    logic [1:0] e_id;
    logic       e_err;
    logic [3:0] e_n, e_x, e_m;
    logic       e_busy;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("check %s ok value=%0h", name, act);
    end
  endtask

  // Reference counter: popcount, highest and lowest set-bit index.
  function automatic logic [11:0] model(input logic [7:0] w);
    logic [3:0] n, x, m;
    logic found;
    n = 0; x = 0; m = 0; found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (w[i]) begin
        n = n + 4'd1;
        x = 4'(i);
        if (!found) begin
          m = 4'(i);
          found = 1'b1;
        end
      end
    end
    return {n, x, m};
  endfunction

  task automatic next_cycle;
    @(negedge clk);
  endtask

  // One full transaction: wait for grant g, counter answers k cycles after ISSUE.
  task automatic transact(input int g, input int k, input bit drop);
    int n;
    logic [11:0] res;
    n = 0;
    res = model(words[g]);
    while (bus.req_ready == '0 && n < 20) begin
      next_cycle; #1;
      n++;
    end
    chk($sformatf("grant%0d", g), 64'(bus.req_ready), 64'(4'b0001 << g));
    next_cycle;
    if (drop) bus.req_valid[g] = 1'b0;
    #1;
    chk($sformatf("issue%0d", g), {bus.cnt_data_valid, bus.cnt_data_in}, {1'b1, words[g]});
    for (int j = 1; j < k; j++) begin
      next_cycle; #1;
    end
    next_cycle;
    bus.cnt_data_ready = 1'b1;
    {bus.cnt_num_of_one, bus.cnt_max_index, bus.cnt_min_index} = res;
    #1;
    next_cycle;
    bus.cnt_data_ready = 1'b0;
    #1;
    chk($sformatf("resp%0d", g),
        {bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_num_of_one, bus.rsp_max_index, bus.rsp_min_index},
        {1'b1, 2'(g), 1'b0, res});
    next_cycle; #1;
  endtask

  task automatic do_reset;
    next_cycle;
    rstn = 1'b0;
    bus.req_valid = '0;
    bus.cnt_data_ready = 1'b0;
    next_cycle; next_cycle;
    #1;
    rstn = 1'b1;
    #1;
  endtask

  initial begin
    int n;
    words[0] = 8'hA5; words[1] = 8'h7E; words[2] = 8'h3A; words[3] = 8'hC3;
    rstn = 1'b0;
    bus.req_valid = '0;
    bus.cnt_data_ready = 1'b0;
    bus.cnt_num_of_one = '0; bus.cnt_max_index = '0; bus.cnt_min_index = '0;
    for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = words[i];

    //             rv       crdy cn  cx  cm  e_rr     cv  cdin   rsp id  err n   x   m   busy
    tbl[0]  = '{4'b0100, 0, 0,  0,  0,  4'b0100, 0, 8'h00, 0, 0, 0, 0,  0,  0,  0};
    tbl[1]  = '{4'b0000, 0, 0,  0,  0,  4'b0000, 1, 8'h3A, 0, 0, 0, 0,  0,  0,  1};
    tbl[2]  = '{4'b0000, 0, 0,  0,  0,  4'b0000, 0, 8'h3A, 0, 0, 0, 0,  0,  0,  1};
    tbl[3]  = '{4'b0000, 0, 0,  0,  0,  4'b0000, 0, 8'h3A, 0, 0, 0, 0,  0,  0,  1};
    tbl[4]  = '{4'b0000, 1, 4,  5,  1,  4'b0000, 0, 8'h3A, 0, 0, 0, 0,  0,  0,  1};
    tbl[5]  = '{4'b0000, 0, 0,  0,  0,  4'b0000, 0, 8'h3A, 1, 2, 0, 4,  5,  1,  1};
    tbl[6]  = '{4'b0000, 0, 0,  0,  0,  4'b0000, 0, 8'h3A, 0, 2, 0, 4,  5,  1,  0};
    tbl[7]  = '{4'b0000, 1, 9,  9,  9,  4'b0000, 0, 8'h3A, 0, 2, 0, 4,  5,  1,  0};
    tbl[8]  = '{4'b0001, 1, 7,  7,  7,  4'b0001, 0, 8'h3A, 0, 2, 0, 4,  5,  1,  0};
    tbl[9]  = '{4'b0000, 1, 7,  7,  7,  4'b0000, 1, 8'hA5, 0, 2, 0, 4,  5,  1,  1};
    tbl[10] = '{4'b0000, 0, 0,  0,  0,  4'b0000, 0, 8'hA5, 0, 2, 0, 4,  5,  1,  1};
    tbl[11] = '{4'b0000, 1, 4,  7,  0,  4'b0000, 0, 8'hA5, 0, 2, 0, 4,  5,  1,  1};
    tbl[12] = '{4'b0000, 0, 0,  0,  0,  4'b0000, 0, 8'hA5, 1, 0, 0, 4,  7,  0,  1};
    tbl[13] = '{4'b0000, 0, 0,  0,  0,  4'b0000, 0, 8'hA5, 0, 0, 0, 4,  7,  0,  0};

    // Reset state, with requests pending that must not be granted during reset.
    next_cycle;
    bus.req_valid = 4'b1111;
    #1;
    chk("reset_outputs",
        {bus.req_ready, bus.cnt_data_valid, bus.cnt_data_in, bus.rsp_valid, bus.rsp_id, bus.rsp_err,
         bus.rsp_num_of_one, bus.rsp_max_index, bus.rsp_min_index, bus.busy, bus.err_count}, 64'd0);
    bus.req_valid = '0;
    next_cycle; #1;
    rstn = 1'b1;

    // Single request, stray readies in IDLE and ISSUE.
    for (int i = 0; i < 14; i++) begin
      next_cycle;
      bus.req_valid = tbl[i].rv;
      bus.cnt_data_ready = tbl[i].crdy;
      bus.cnt_num_of_one = tbl[i].cn;
      bus.cnt_max_index = tbl[i].cx;
      bus.cnt_min_index = tbl[i].cm;
      #1;
      chk($sformatf("vec%0d", i),
          {bus.req_ready, bus.cnt_data_valid, bus.cnt_data_in, bus.rsp_valid, bus.rsp_id, bus.rsp_err,
           bus.rsp_num_of_one, bus.rsp_max_index, bus.rsp_min_index, bus.busy},
          {tbl[i].e_rr, tbl[i].e_cv, tbl[i].e_cdin, tbl[i].e_rsp, tbl[i].e_id, tbl[i].e_err,
           tbl[i].e_n, tbl[i].e_x, tbl[i].e_m, tbl[i].e_busy});
    end
    bus.cnt_data_ready = 1'b0;

    // All four continuously valid: rotation 0,1,2,3,0.
    do_reset;
    bus.req_valid = 4'b1111;
    #1;
    transact(0, 1, 1'b0);
    transact(1, 2, 1'b0);
    chk("word7E_result", {bus.rsp_num_of_one, bus.rsp_max_index, bus.rsp_min_index}, {4'd6, 4'd6, 4'd1});
    transact(2, 3, 1'b0);
    transact(3, 1, 1'b0);
    transact(0, 2, 1'b0);
    bus.req_valid = '0;

    // Fairness after the pointer has moved past requester 1.
    do_reset;
    bus.req_valid = 4'b0010;
    #1;
    transact(1, 1, 1'b1);
    bus.req_valid = 4'b1001;
    #1;
    transact(3, 1, 1'b1);
    transact(0, 1, 1'b1);

    // Watchdog timeout, then a normal transaction.
    bus.req_valid = 4'b0100;
    #1;
    n = 0;
    while (bus.req_ready == '0 && n < 20) begin
      next_cycle; #1;
      n++;
    end
    chk("to_grant", 64'(bus.req_ready), 64'(4'b0100));
    next_cycle;
    bus.req_valid = '0;
    #1;
    chk("to_issue", 64'(bus.cnt_data_valid), 64'd1);
    n = 0;
    while (n < 40) begin
      next_cycle; #1;
      n++;
      if (bus.rsp_valid) break;
    end
    chk("to_latency", 64'(n), 64'd16);
    chk("to_resp", {bus.rsp_id, bus.rsp_err, bus.rsp_num_of_one, bus.rsp_max_index, bus.rsp_min_index},
        {2'd2, 1'b1, 12'd0});
    chk("to_err_count", 64'(bus.err_count), 64'd1);
    next_cycle;
    bus.req_valid = 4'b1000;
    #1;
    transact(3, 2, 1'b1);
    chk("err_count_hold", 64'(bus.err_count), 64'd1);

    // Reset while waiting on the counter.
    bus.req_valid = 4'b0100;
    #1;
    transact(2, 1, 1'b1);
    bus.req_valid = 4'b0100;
    #1;
    chk("rw_grant", 64'(bus.req_ready), 64'(4'b0100));
    next_cycle;
    bus.req_valid = '0;
    next_cycle; next_cycle;
    #1;
    chk("rw_in_wait", {bus.busy, bus.rsp_valid}, 2'b10);
    bus.req_valid = 4'b1001;
    rstn = 1'b0;
    #1;
    chk("rw_reset_now", {bus.busy, bus.rsp_valid, bus.req_ready, bus.err_count}, 64'd0);
    n = 0;
    for (int j = 0; j < 3; j++) begin
      next_cycle; #1;
      if (bus.rsp_valid || bus.req_ready != '0) n++;
    end
    rstn = 1'b1;
    #1;
    chk("rw_no_stale", 64'(n), 64'd0);
    chk("rw_ptr0_grant", 64'(bus.req_ready), 64'(4'b0001));
    transact(0, 1, 1'b1);
    bus.req_valid = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
